// File: rtl/bpred_btb_if.sv
// Fetch/MEM-side bus of the branch predictor: lookup request, registered prediction,
// resolved-branch training, init status and mispredict statistics.
interface bpred_btb_if #(
  parameter int ENTRIES_LOG2 = 10
);
  logic                    lookup_en;
  logic [31:0]             lookup_pc;
  logic                    stall;
  logic                    pred_hit;
  logic                    pred_taken;
  logic [31:0]             pred_next_pc;
  logic [ENTRIES_LOG2-1:0] pred_ghr;
  logic                    upd_valid;
  logic [31:0]             upd_pc;
  logic                    upd_taken;
  logic [31:0]             upd_target;
  logic                    upd_mispredict;
  logic [ENTRIES_LOG2-1:0] upd_ghr;
  logic                    busy;
  logic [31:0]             stat_mispredicts;

  modport master (
    output lookup_en, lookup_pc, stall,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, upd_ghr,
    input  pred_hit, pred_taken, pred_next_pc, pred_ghr, busy, stat_mispredicts
  );

  modport slave (
    input  lookup_en, lookup_pc, stall,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, upd_ghr,
    output pred_hit, pred_taken, pred_next_pc, pred_ghr, busy, stat_mispredicts
  );
endinterface

// File: rtl/bpred_btb.sv
// Tagged BTB with saturating-counter direction prediction and post-reset table clear.
// Optional gshare indexing is enabled by defining BPRED_GSHARE_EN.
module bpred_btb #(
  parameter int ENTRIES_LOG2 = 10,
  parameter int TAG_W        = 8,
  parameter int CTR_W        = 2
) (
  input logic         clk,
  input logic         rst,
  bpred_btb_if.slave  bus
);
  localparam int DEPTH = 1 << ENTRIES_LOG2;
  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
  localparam logic [CTR_W-1:0] CTR_ONE     = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX     = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_ONE << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_ONE;

  typedef logic [ENTRIES_LOG2-1:0] idx_t;
  typedef logic [TAG_W-1:0]        tag_t;
  typedef struct packed {
    logic          valid;
    tag_t          tag;
    logic [31:0]   target;
    logic [CTR_W-1:0] ctr;
  } entry_t;

  entry_t     mem [DEPTH];
  logic [0:0] state_reg;
  idx_t       init_idx_reg;
  logic       ready;
  logic       upd_accept;
  logic       lk_fire;

  assign ready      = (state_reg == ST_READY);
  assign upd_accept = ready && bus.upd_valid;
  assign lk_fire    = bus.lookup_en && !bus.stall;

  // Tags are never hashed; only the index sees the history in gshare mode.
  tag_t lk_tag, up_tag;
  idx_t lk_idx, up_idx, lk_ghr;
  assign lk_tag = bus.lookup_pc[ENTRIES_LOG2+TAG_W+1:ENTRIES_LOG2+2];
  assign up_tag = bus.upd_pc[ENTRIES_LOG2+TAG_W+1:ENTRIES_LOG2+2];

`ifdef BPRED_GSHARE_EN
  idx_t ghr_reg;
  always_ff @(posedge clk) begin
    if (rst)
      ghr_reg <= '0;
    else if (upd_accept)
      ghr_reg <= (ghr_reg << 1) | idx_t'(bus.upd_taken);
  end
  assign lk_idx = bus.lookup_pc[ENTRIES_LOG2+1:2] ^ ghr_reg;
  assign up_idx = bus.upd_pc[ENTRIES_LOG2+1:2] ^ bus.upd_ghr;
  assign lk_ghr = ghr_reg;
`else
  logic unused_upd_ghr;
  assign unused_upd_ghr = ^bus.upd_ghr;
  assign lk_idx = bus.lookup_pc[ENTRIES_LOG2+1:2];
  assign up_idx = bus.upd_pc[ENTRIES_LOG2+1:2];
  assign lk_ghr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_INIT;
      init_idx_reg <= '0;
    end else if (state_reg == ST_INIT) begin
      init_idx_reg <= init_idx_reg + idx_t'(1);
      if (init_idx_reg == idx_t'(DEPTH - 1))
        state_reg <= ST_READY;
    end
  end

  // Training reads the entry asynchronously so an update commits in the same edge.
  entry_t up_cur, wr_data;
  idx_t   wr_idx;
  logic   wr_en, up_hit;
  assign up_cur = mem[up_idx];
  assign up_hit = up_cur.valid && (up_cur.tag == up_tag);

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = up_idx;
    wr_data = up_cur;
    if (state_reg == ST_INIT) begin
      wr_en   = 1'b1;
      wr_idx  = init_idx_reg;
      wr_data = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};
    end else if (bus.upd_valid) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (bus.upd_taken) begin
          wr_data.target = bus.upd_target;
          if (up_cur.ctr != CTR_MAX)
            wr_data.ctr = up_cur.ctr + CTR_ONE;
        end else if (up_cur.ctr != '0) begin
          wr_data.ctr = up_cur.ctr - CTR_ONE;
        end
      end else if (bus.upd_taken) begin
        wr_en   = 1'b1;
        wr_data = '{valid: 1'b1, tag: up_tag, target: bus.upd_target, ctr: CTR_WEAK_T};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_idx] <= wr_data;
  end

  // Registered read is read-first, so a colliding update is not visible to this lookup.
  entry_t      rd_entry_reg;
  tag_t        lk_tag_reg;
  logic        lk_ready_reg;
  logic [31:0] seq_pc_reg;
  idx_t        pred_ghr_reg;

  always_ff @(posedge clk) begin
    if (lk_fire)
      rd_entry_reg <= mem[lk_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_tag_reg   <= '0;
      lk_ready_reg <= 1'b0;
      seq_pc_reg   <= '0;
      pred_ghr_reg <= '0;
    end else if (lk_fire) begin
      lk_tag_reg   <= lk_tag;
      lk_ready_reg <= ready;
      seq_pc_reg   <= bus.lookup_pc + 32'd4;
      pred_ghr_reg <= lk_ghr;
    end
  end

  assign bus.pred_hit     = lk_ready_reg && rd_entry_reg.valid && (rd_entry_reg.tag == lk_tag_reg);
  assign bus.pred_taken   = bus.pred_hit && rd_entry_reg.ctr[CTR_W-1];
  assign bus.pred_next_pc = bus.pred_taken ? rd_entry_reg.target : seq_pc_reg;
  assign bus.pred_ghr     = pred_ghr_reg;
  assign bus.busy         = (state_reg == ST_INIT);

  logic [31:0] stat_reg;
  always_ff @(posedge clk) begin
    if (rst)
      stat_reg <= '0;
    else if (upd_accept && bus.upd_mispredict && (stat_reg != 32'hFFFF_FFFF))
      stat_reg <= stat_reg + 32'd1;
  end
  assign bus.stat_mispredicts = stat_reg;
endmodule

// File: tb/tb_bpred_btb.sv
// Directed bench for bpred_btb (ENTRIES_LOG2=4, TAG_W=8, CTR_W=2): init timing,
// allocation, counter saturation, tag conflict, stall hold, collision and reset mid-init.
module tb_bpred_btb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_cycles;

  always #5 clk = ~clk;

  bpred_btb_if #(.ENTRIES_LOG2(4)) bus ();

  bpred_btb #(.ENTRIES_LOG2(4), .TAG_W(8), .CTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [31:0] pc);
    bus.lookup_en = 1'b1;
    bus.lookup_pc = pc;
    step();
    bus.lookup_en = 1'b0;
    $display("lookup pc=%h -> hit=%0d taken=%0d next=%h ghr=%0d", pc,
             bus.pred_hit, bus.pred_taken, bus.pred_next_pc, bus.pred_ghr);
  endtask

  task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic mis);
    bus.upd_valid      = 1'b1;
    bus.upd_pc         = pc;
    bus.upd_taken      = tk;
    bus.upd_target     = tgt;
    bus.upd_mispredict = mis;
    step();
    bus.upd_valid      = 1'b0;
    bus.upd_mispredict = 1'b0;
    $display("update pc=%h taken=%0d target=%h mispredict=%0d", pc, tk, tgt, mis);
  endtask

  task automatic expect_pred(input string tag, input logic hit, input logic tk,
                             input logic [31:0] nxt);
    check({tag, ".hit"},   32'(bus.pred_hit),   32'(hit));
    check({tag, ".taken"}, 32'(bus.pred_taken), 32'(tk));
    check({tag, ".next"},  bus.pred_next_pc,    nxt);
  endtask

  task automatic count_busy();
    busy_cycles = 0;
    while (bus.busy && busy_cycles < 100) begin
      busy_cycles++;
      step();
    end
  endtask

  initial begin
    bus.lookup_en = 1'b0; bus.lookup_pc = '0; bus.stall = 1'b0;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
    bus.upd_target = '0; bus.upd_mispredict = 1'b0; bus.upd_ghr = '0;

    // Reset and init length
    step();
    rst = 1'b0;
    check("rst.busy",  32'(bus.busy), 32'd1);
    check("rst.stat",  bus.stat_mispredicts, 32'd0);
    check("rst.ghr",   32'(bus.pred_ghr), 32'd0);
    expect_pred("rst", 1'b0, 1'b0, 32'h0);
    count_busy();
    $display("init done after %0d busy cycles", busy_cycles);
    check("init.cycles", 32'(busy_cycles), 32'd16);

    lookup(32'h40);
    expect_pred("empty", 1'b0, 1'b0, 32'h44);

    // Allocate and hit
    update(32'h100, 1'b1, 32'h200, 1'b0);
    lookup(32'h100);
    expect_pred("alloc", 1'b1, 1'b1, 32'h200);

    // Counter saturation: 2 -> 3 (sat), then down
    repeat (3) update(32'h100, 1'b1, 32'h200, 1'b0);
    update(32'h100, 1'b0, 32'h0, 1'b0);
    lookup(32'h100);
    expect_pred("sat.nt1", 1'b1, 1'b1, 32'h200);
    update(32'h100, 1'b0, 32'h0, 1'b1);
    lookup(32'h100);
    expect_pred("sat.nt2", 1'b1, 1'b0, 32'h104);
    repeat (2) update(32'h100, 1'b0, 32'h0, 1'b0);
    update(32'h100, 1'b1, 32'h200, 1'b0);
    lookup(32'h100);
    expect_pred("sat.floor", 1'b1, 1'b0, 32'h104);
    update(32'h100, 1'b1, 32'h200, 1'b0);
    lookup(32'h100);
    expect_pred("sat.up2", 1'b1, 1'b1, 32'h200);

    // Tag conflict on index 0
    update(32'h1100, 1'b1, 32'h500, 1'b1);
    lookup(32'h100);
    expect_pred("conf.old", 1'b0, 1'b0, 32'h104);
    lookup(32'h1100);
    expect_pred("conf.new", 1'b1, 1'b1, 32'h500);
    check("stat.two", bus.stat_mispredicts, 32'd2);

    // Stall holds outputs, as does an idle cycle
    bus.stall = 1'b1;
    bus.lookup_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.lookup_pc = 32'h40 * i;
      step();
      expect_pred($sformatf("stall%0d", i), 1'b1, 1'b1, 32'h500);
    end
    bus.stall = 1'b0;
    bus.lookup_en = 1'b0;
    step();
    expect_pred("idle.hold", 1'b1, 1'b1, 32'h500);

    // Same-cycle lookup and allocating update: read-before-write
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h300; bus.upd_taken = 1'b1;
    bus.upd_target = 32'h700; bus.upd_mispredict = 1'b0;
    lookup(32'h300);
    bus.upd_valid = 1'b0;
    expect_pred("coll.same", 1'b0, 1'b0, 32'h304);
    lookup(32'h300);
    expect_pred("coll.next", 1'b1, 1'b1, 32'h700);

    lookup(32'hFFFF_FFFC);
    expect_pred("wrap", 1'b0, 1'b0, 32'h0);

    // Reset at INIT cycle 7, lookups during INIT miss
    rst = 1'b1;
    step();
    rst = 1'b0;
    lookup(32'h300);
    expect_pred("init.lookup", 1'b0, 1'b0, 32'h304);
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2.busy", 32'(bus.busy), 32'd1);
    expect_pred("rst2", 1'b0, 1'b0, 32'h0);
    busy_cycles = 0;
    while (bus.busy && busy_cycles < 100) begin
      bus.upd_valid = (busy_cycles == 8);
      bus.upd_pc = 32'h300; bus.upd_taken = 1'b1;
      bus.upd_target = 32'h900; bus.upd_mispredict = 1'b1;
      busy_cycles++;
      step();
    end
    bus.upd_valid = 1'b0;
    bus.upd_mispredict = 1'b0;
    $display("re-init done after %0d busy cycles", busy_cycles);
    check("rst2.cycles", 32'(busy_cycles), 32'd16);
    check("rst2.stat", bus.stat_mispredicts, 32'd0);
    lookup(32'h300);
    expect_pred("rst2.clear", 1'b0, 1'b0, 32'h304);

`ifdef BPRED_GSHARE_EN
    update(32'h100, 1'b1, 32'h200, 1'b0);
    update(32'h100, 1'b1, 32'h200, 1'b0);
    lookup(32'h100);
    check("ghr.three", 32'(bus.pred_ghr), 32'd3);
`else
    update(32'h100, 1'b1, 32'h200, 1'b0);
    lookup(32'h100);
    check("ghr.off", 32'(bus.pred_ghr), 32'd0);
    expect_pred("final", 1'b1, 1'b1, 32'h200);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
